spram_chan_arbiter: RTL and testbench

Arbitrates one single-port channel RAM between two requesters using the same req/resp/wr_comp channel protocol. It lets the LZ4 encoder's history-buffer or hash-table RAM be shared, for example between the encoder and a debug/initialisation engine, or lets HB and HT be folded into one physical RAM. The block has round-robin request arbitration with grant locking and an in-order tag FIFO that routes each RAM response or write completion back to the requester that issued it.

---
 rtl/spram_arb_pkg.sv | 29 ++
 rtl/spram_arb_tag_fifo.sv | 57 +++++
 rtl/spram_chan_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spram_chan_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the single-port channel RAM arbiter: request field
// positions, transaction kind encoding and the in-order tag layout.
package spram_arb_pkg;

  localparam int unsigned DataLsb = 0;

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned re_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

  function automatic int unsigned we_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw + 1;
  endfunction

  typedef enum logic {
    KindRead  = 1'b0,
    KindWrite = 1'b1
  } kind_e;

  typedef struct packed {
    logic  id;
    kind_e kind;
  } tag_t;

endpackage

// File: rtl/spram_arb_tag_fifo.sv
// In-order FIFO of outstanding transaction tags; the caller never pushes when
// full nor pops when empty.
module spram_arb_tag_fifo
  import spram_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  tag_t                     wdata_i,
  output tag_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  tag_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/spram_chan_arbiter.sv
// Shares one single-port channel RAM between two requesters: round-robin grant
// with locking under backpressure, responses routed back in issue order.
module spram_chan_arbiter
  import spram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TAG_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] s0_req_data,
  input  logic                             s0_req_vld,
  output logic                             s0_req_rdy,
  output logic [DATA_WIDTH-1:0]            s0_resp_data,
  output logic                             s0_resp_vld,
  input  logic                             s0_resp_rdy,
  output logic                             s0_wr_comp_vld,
  input  logic                             s0_wr_comp_rdy,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] s1_req_data,
  input  logic                             s1_req_vld,
  output logic                             s1_req_rdy,
  output logic [DATA_WIDTH-1:0]            s1_resp_data,
  output logic                             s1_resp_vld,
  input  logic                             s1_resp_rdy,
  output logic                             s1_wr_comp_vld,
  input  logic                             s1_wr_comp_rdy,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] m_req_data,
  output logic                             m_req_vld,
  input  logic                             m_req_rdy,
  input  logic [DATA_WIDTH-1:0]            m_resp_data,
  input  logic                             m_resp_vld,
  output logic                             m_resp_rdy,
  input  logic                             m_wr_comp_vld,
  output logic                             m_wr_comp_rdy
);

  localparam int unsigned WeBit = we_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CntW  = $clog2(TAG_DEPTH) + 1;

  logic            rr_ptr_q, rr_ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic            lock_id_q, lock_id_d;
  logic            sel, sel_vld, not_full, accept, pop;
  logic            full, empty;
  logic [CntW-1:0] count;
  tag_t            push_tag, head;

  // Selection: a locked grant overrides round-robin.
  always_comb begin
    sel     = rr_ptr_q;
    sel_vld = 1'b0;
    if (lock_vld_q) begin
      sel     = lock_id_q;
      sel_vld = lock_id_q ? s1_req_vld : s0_req_vld;
    end else begin
      case ({s1_req_vld, s0_req_vld})
        2'b01: begin
          sel     = 1'b0;
          sel_vld = 1'b1;
        end
        2'b10: begin
          sel     = 1'b1;
          sel_vld = 1'b1;
        end
        2'b11: begin
          sel     = rr_ptr_q;
          sel_vld = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign not_full   = (count < CntW'(TAG_DEPTH));
  assign m_req_vld  = sel_vld & not_full;
  assign m_req_data = sel ? s1_req_data : s0_req_data;
  assign s0_req_rdy = m_req_rdy & not_full & ~sel;
  assign s1_req_rdy = m_req_rdy & not_full & sel;
  assign accept     = m_req_vld & m_req_rdy;

  assign push_tag = '{id: sel, kind: kind_e'(m_req_data[WeBit])};

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (accept) begin
      rr_ptr_d   = ~sel;
      lock_vld_d = 1'b0;
    end else if (m_req_vld) begin
      // Stalled by the RAM: pin the grant so the presented request stays stable.
      lock_vld_d = 1'b1;
      lock_id_d  = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

  spram_arb_tag_fifo #(
    .Depth (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (push_tag),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Responses not matching the head tag's kind see rdy=0 and wait.
  always_comb begin
    s0_resp_vld    = 1'b0;
    s1_resp_vld    = 1'b0;
    s0_resp_data   = '0;
    s1_resp_data   = '0;
    s0_wr_comp_vld = 1'b0;
    s1_wr_comp_vld = 1'b0;
    m_resp_rdy     = 1'b0;
    m_wr_comp_rdy  = 1'b0;
    if (!empty) begin
      if (head.kind == KindRead) begin
        if (head.id) begin
          s1_resp_vld  = m_resp_vld;
          s1_resp_data = m_resp_data;
          m_resp_rdy   = s1_resp_rdy;
        end else begin
          s0_resp_vld  = m_resp_vld;
          s0_resp_data = m_resp_data;
          m_resp_rdy   = s0_resp_rdy;
        end
      end else begin
        if (head.id) begin
          s1_wr_comp_vld = m_wr_comp_vld;
          m_wr_comp_rdy  = s1_wr_comp_rdy;
        end else begin
          s0_wr_comp_vld = m_wr_comp_vld;
          m_wr_comp_rdy  = s0_wr_comp_rdy;
        end
      end
    end
  end

  assign pop = (m_resp_vld & m_resp_rdy) | (m_wr_comp_vld & m_wr_comp_rdy);

  a_full_consistent: assert property (@(posedge clk) disable iff (!rst)
    full == (count == CntW'(TAG_DEPTH)));

endmodule

// File: tb/tb_spram_chan_arbiter.sv
// Directed bench for spram_chan_arbiter: a behavioural in-order RAM on the
// master side, scoreboard queues of expected grants and per-requester responses.
module tb_spram_chan_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned RW = AW + DW + 2;
  localparam int unsigned TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW-1:0] s0_req_data, s1_req_data, m_req_data;
  logic          s0_req_vld, s0_req_rdy, s1_req_vld, s1_req_rdy;
  logic [DW-1:0] s0_resp_data, s1_resp_data, m_resp_data;
  logic          s0_resp_vld, s0_resp_rdy, s1_resp_vld, s1_resp_rdy;
  logic          s0_wr_comp_vld, s0_wr_comp_rdy, s1_wr_comp_vld, s1_wr_comp_rdy;
  logic          m_req_vld, m_req_rdy, m_resp_vld, m_resp_rdy;
  logic          m_wr_comp_vld, m_wr_comp_rdy;

  always #5 clk = ~clk;

  spram_chan_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_req_data    (s0_req_data),
    .s0_req_vld     (s0_req_vld),
    .s0_req_rdy     (s0_req_rdy),
    .s0_resp_data   (s0_resp_data),
    .s0_resp_vld    (s0_resp_vld),
    .s0_resp_rdy    (s0_resp_rdy),
    .s0_wr_comp_vld (s0_wr_comp_vld),
    .s0_wr_comp_rdy (s0_wr_comp_rdy),
    .s1_req_data    (s1_req_data),
    .s1_req_vld     (s1_req_vld),
    .s1_req_rdy     (s1_req_rdy),
    .s1_resp_data   (s1_resp_data),
    .s1_resp_vld    (s1_resp_vld),
    .s1_resp_rdy    (s1_resp_rdy),
    .s1_wr_comp_vld (s1_wr_comp_vld),
    .s1_wr_comp_rdy (s1_wr_comp_rdy),
    .m_req_data     (m_req_data),
    .m_req_vld      (m_req_vld),
    .m_req_rdy      (m_req_rdy),
    .m_resp_data    (m_resp_data),
    .m_resp_vld     (m_resp_vld),
    .m_resp_rdy     (m_resp_rdy),
    .m_wr_comp_vld  (m_wr_comp_vld),
    .m_wr_comp_rdy  (m_wr_comp_rdy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: grants are {id, req_data}; responses are {kind, data}.
  logic [RW:0] exp_grant[$];
  logic [DW:0] exp_s0[$];
  logic [DW:0] exp_s1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rd_req(input logic [AW-1:0] a);
    return {2'b01, a, {DW{1'b0}}};
  endfunction

  function automatic logic [RW-1:0] wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {2'b10, a, d};
  endfunction

  // ---------------- RAM model (environment, in-order, gated by enables)
  logic          resp_en = 1'b1;
  logic          comp_en = 1'b1;
  logic [DW-1:0] mem [0:65535];
  logic [DW:0]   pend[$];

  initial begin
    logic          acc, rd, wc, rs;
    logic [RW-1:0] req;
    m_resp_vld    = 1'b0;
    m_wr_comp_vld = 1'b0;
    m_resp_data   = '0;
    forever begin
      @(negedge clk);
      acc = m_req_vld && m_req_rdy;
      req = m_req_data;
      rd  = m_resp_vld && m_resp_rdy;
      wc  = m_wr_comp_vld && m_wr_comp_rdy;
      rs  = rst;
      @(posedge clk);
      #2;
      if (!rs) begin
        pend.delete();
      end else begin
        if (rd || wc) void'(pend.pop_front());
        if (acc) begin
          if (req[RW-1]) begin
            mem[req[AW+DW-1:DW]] = req[DW-1:0];
            pend.push_back({1'b1, {DW{1'b0}}});
          end else begin
            pend.push_back({1'b0, mem[req[AW+DW-1:DW]]});
          end
        end
      end
      m_resp_vld    = (pend.size() > 0) && !pend[0][DW] && resp_en;
      m_wr_comp_vld = (pend.size() > 0) && pend[0][DW] && comp_en;
      m_resp_data   = (pend.size() > 0) ? pend[0][DW-1:0] : '0;
    end
  end

  // ---------------- Monitor: pops the scoreboard on every handshake
  logic [RW:0] mon_g;
  logic [DW:0] mon_r;

  always @(negedge clk) begin
    if (rst) begin
      if (m_req_vld && m_req_rdy) begin
        if (exp_grant.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL grant: unexpected grant id=%0d data=%0h, none required", s1_req_rdy,
                   m_req_data);
        end else begin
          mon_g = exp_grant.pop_front();
          check("grant", {s1_req_rdy, m_req_data}, mon_g);
        end
      end
      if ((s0_resp_vld && s0_resp_rdy) || (s0_wr_comp_vld && s0_wr_comp_rdy)) begin
        if (exp_s0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s0_resp: unexpected response, none required");
        end else begin
          mon_r = exp_s0.pop_front();
          if (s0_wr_comp_vld) check("s0_wr_comp", {1'b1, {DW{1'b0}}}, mon_r);
          else check("s0_resp", {1'b0, s0_resp_data}, mon_r);
        end
      end
      if ((s1_resp_vld && s1_resp_rdy) || (s1_wr_comp_vld && s1_wr_comp_rdy)) begin
        if (exp_s1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s1_resp: unexpected response, none required");
        end else begin
          mon_r = exp_s1.pop_front();
          if (s1_wr_comp_vld) check("s1_wr_comp", {1'b1, {DW{1'b0}}}, mon_r);
          else check("s1_resp", {1'b0, s1_resp_data}, mon_r);
        end
      end
    end
  end

  // ---------------- Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic id, input logic [RW-1:0] d, input logic [DW-1:0] rdata,
                            input logic want_resp);
    logic [DW:0] r;
    exp_grant.push_back({id, d});
    r = d[RW-1] ? {1'b1, {DW{1'b0}}} : {1'b0, rdata};
    if (want_resp) begin
      if (id) exp_s1.push_back(r);
      else exp_s0.push_back(r);
    end
  endtask

  task automatic start(input logic id, input logic [RW-1:0] d);
    if (id) begin
      s1_req_data = d;
      s1_req_vld  = 1'b1;
    end else begin
      s0_req_data = d;
      s0_req_vld  = 1'b1;
    end
  endtask

  task automatic run_until_idle();
    int   guard = 0;
    logic a0, a1;
    while ((s0_req_vld || s1_req_vld) && guard < 100) begin
      @(negedge clk);
      a0 = s0_req_vld && s0_req_rdy;
      a1 = s1_req_vld && s1_req_rdy;
      tick();
      if (a0) s0_req_vld = 1'b0;
      if (a1) s1_req_vld = 1'b0;
      guard++;
    end
    if (s0_req_vld || s1_req_vld) begin
      n_cmp++; n_err++;
      $display("FAIL run_until_idle: request still pending after %0d cycles", guard);
      s0_req_vld = 1'b0;
      s1_req_vld = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((exp_grant.size() + exp_s0.size() + exp_s1.size()) != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(name, 64'(exp_grant.size() + exp_s0.size() + exp_s1.size()), 64'd0);
    tick();
  endtask

  task automatic reset_dut();
    rst        = 1'b0;
    s0_req_vld = 1'b0;
    s1_req_vld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- Directed tests
  initial begin
    int n;
    int guard;
    s0_req_data = '0; s1_req_data = '0;
    s0_req_vld = 1'b0; s1_req_vld = 1'b0;
    s0_resp_rdy = 1'b1; s1_resp_rdy = 1'b1;
    s0_wr_comp_rdy = 1'b1; s1_wr_comp_rdy = 1'b1;
    m_req_rdy = 1'b1;
    mem[16'h0010] = 8'hA5;
    mem[16'h0020] = 8'h5A;
    mem[16'h0030] = 8'h11;
    mem[16'h0040] = 8'h22;

    // Reset state
    #1;
    reset_dut();
    @(negedge clk);
    check("reset_outputs", {m_req_vld, s0_resp_vld, s1_resp_vld, s0_wr_comp_vld,
                            s1_wr_comp_vld, m_resp_rdy, m_wr_comp_rdy}, 7'b0);
    tick();

    // Single read
    expect_txn(1'b0, rd_req(16'h0010), 8'hA5, 1'b1);
    start(1'b0, rd_req(16'h0010));
    run_until_idle();
    drain("single_read_drain");

    // Alternating grants from reset: s0, s1, s0, s1
    reset_dut();
    expect_txn(1'b0, rd_req(16'h0010), 8'hA5, 1'b1);
    expect_txn(1'b1, rd_req(16'h0020), 8'h5A, 1'b1);
    expect_txn(1'b0, rd_req(16'h0010), 8'hA5, 1'b1);
    expect_txn(1'b1, rd_req(16'h0020), 8'h5A, 1'b1);
    start(1'b0, rd_req(16'h0010));
    start(1'b1, rd_req(16'h0020));
    n = 0;
    guard = 0;
    while (n < 4 && guard < 100) begin
      @(negedge clk);
      if (m_req_vld && m_req_rdy) n++;
      guard++;
      if (n < 4) tick();
    end
    check("alt_accepts", 64'(n), 64'd4);
    tick();
    s0_req_vld = 1'b0;
    s1_req_vld = 1'b0;
    drain("alt_drain");

    // Lock under stall: prime rr_ptr toward s1, then stall s0 and let s1 arrive
    reset_dut();
    expect_txn(1'b0, wr_req(16'h0002, 8'h77), '0, 1'b1);
    start(1'b0, wr_req(16'h0002, 8'h77));
    run_until_idle();
    drain("lock_prime_drain");
    m_req_rdy = 1'b0;
    expect_txn(1'b0, rd_req(16'h0030), 8'h11, 1'b1);
    expect_txn(1'b1, rd_req(16'h0040), 8'h22, 1'b1);
    start(1'b0, rd_req(16'h0030));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_stall_vld", m_req_vld, 1'b1);
      check("lock_stall_data", m_req_data, rd_req(16'h0030));
      tick();
    end
    start(1'b1, rd_req(16'h0040));
    @(negedge clk);
    check("lock_hold_data", m_req_data, rd_req(16'h0030));
    tick();
    m_req_rdy = 1'b1;
    run_until_idle();
    drain("lock_drain");

    // Full tag FIFO: four writes from s1 with completions withheld
    reset_dut();
    comp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_txn(1'b1, wr_req(16'h0100 + 16'(i), 8'h80 + 8'(i)), '0, 1'b1);
      start(1'b1, wr_req(16'h0100 + 16'(i), 8'h80 + 8'(i)));
      run_until_idle();
    end
    expect_txn(1'b1, wr_req(16'h0104, 8'h84), '0, 1'b1);
    start(1'b1, wr_req(16'h0104, 8'h84));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_s1_rdy", s1_req_rdy, 1'b0);
      check("full_m_req_vld", m_req_vld, 1'b0);
      tick();
    end
    comp_en = 1'b1;
    @(negedge clk);
    tick();
    comp_en = 1'b0;
    @(negedge clk);
    check("refill_s1_rdy", s1_req_rdy, 1'b1);
    check("refill_m_req_vld", m_req_vld, 1'b1);
    tick();
    s1_req_vld = 1'b0;
    comp_en = 1'b1;
    drain("full_drain");

    // Mixed routing with backpressure on s1
    reset_dut();
    expect_txn(1'b0, wr_req(16'h0001, 8'h3C), '0, 1'b1);
    start(1'b0, wr_req(16'h0001, 8'h3C));
    run_until_idle();
    drain("mixed_write_drain");
    s1_resp_rdy = 1'b0;
    expect_txn(1'b1, rd_req(16'h0001), 8'h3C, 1'b1);
    start(1'b1, rd_req(16'h0001));
    run_until_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_m_resp_rdy", m_resp_rdy, 1'b0);
      check("stall_s1_resp_vld", s1_resp_vld, 1'b1);
      check("stall_s0_resp_vld", s0_resp_vld, 1'b0);
      tick();
    end
    s1_resp_rdy = 1'b1;
    drain("mixed_read_drain");

    // Reset with three tags outstanding; last grant was s0 so rr_ptr points at s1
    reset_dut();
    comp_en = 1'b0;
    resp_en = 1'b0;
    expect_txn(1'b1, wr_req(16'h0200, 8'h01), '0, 1'b0);
    expect_txn(1'b1, wr_req(16'h0201, 8'h02), '0, 1'b0);
    expect_txn(1'b0, wr_req(16'h0202, 8'h03), '0, 1'b0);
    start(1'b1, wr_req(16'h0200, 8'h01));
    run_until_idle();
    start(1'b1, wr_req(16'h0201, 8'h02));
    run_until_idle();
    start(1'b0, wr_req(16'h0202, 8'h03));
    run_until_idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    comp_en = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {m_req_vld, s0_resp_vld, s1_resp_vld, s0_wr_comp_vld,
                             s1_wr_comp_vld, m_resp_rdy, m_wr_comp_rdy}, 7'b0);
    tick();
    expect_txn(1'b0, rd_req(16'h0030), 8'h11, 1'b1);
    expect_txn(1'b1, rd_req(16'h0040), 8'h22, 1'b1);
    start(1'b0, rd_req(16'h0030));
    start(1'b1, rd_req(16'h0040));
    run_until_idle();
    drain("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
